// File: rtl/fp_uart_rx_byte.sv
// ---------------------------------------------------------------------------
// fp_uart_rx_byte
//   8N1 UART receiver for a fingerprint sensor serial link. The line is
//   synchronized, a frame starts on a falling edge, and each bit is sampled
//   near the centre of its bit period. A byte whose stop bit reads low is
//   dropped and reported as a framing error.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       serial bit rate; BAUD_DIV = CLK_FREQ/BAUD clocks per bit
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   rxd         in   asynchronous serial input, idle high
//   data_byte   out  [7:0] last correctly framed byte (LSB received first)
//   byte_valid  out  one-cycle pulse, data_byte freshly loaded
//   rx_busy     out  high while a frame is being received
//   frame_err   out  one-cycle pulse when a stop bit samples low
//
// Build option
//   FP_UART_RX_MAJORITY_EN  when defined, each bit is the 2-of-3 majority of
//                           samples at BAUD_DIV/2-1, BAUD_DIV/2, BAUD_DIV/2+1,
//                           decided at BAUD_DIV/2+1 (one clock later than the
//                           default single sample at BAUD_DIV/2).
// ---------------------------------------------------------------------------
module fp_uart_rx_byte #(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 57600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int HALF     = BAUD_DIV / 2;
    localparam int CNT_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_DIV - 1);
`ifdef FP_UART_RX_MAJORITY_EN
    localparam logic [CNT_W-1:0] CNT_S0     = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_S1     = CNT_W'(HALF);
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF + 1);
`else
    localparam logic [CNT_W-1:0] CNT_DECIDE = CNT_W'(HALF);
`endif

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_HIGH = 3'd4;

    logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
    logic [1:0]       flush_q, flush_d;
    logic             line_ok_q, line_ok_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_byte_q, data_byte_d;
    logic             byte_valid_q, byte_valid_d;
    logic             rx_busy_q, rx_busy_d;
    logic             frame_err_q, frame_err_d;
    logic             bit_val;
    logic             sample_now;
    logic             fall_edge;

`ifdef FP_UART_RX_MAJORITY_EN
    logic samp0_q, samp0_d;
    logic samp1_q, samp1_d;

    always_comb begin
        samp0_d = (cnt_q == CNT_S0) ? rxd_sync_q : samp0_q;
        samp1_d = (cnt_q == CNT_S1) ? rxd_sync_q : samp1_q;
        bit_val = (samp0_q & samp1_q) | (samp0_q & rxd_sync_q) | (samp1_q & rxd_sync_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp0_q <= 1'b0;
            samp1_q <= 1'b0;
        end else begin
            samp0_q <= samp0_d;
            samp1_q <= samp1_d;
        end
    end
`else
    assign bit_val = rxd_sync_q;
`endif

    assign sample_now = (cnt_q == CNT_DECIDE);

    // The synchronizer resets to 1, so a line held low across reset release
    // would look like a falling edge. Edges only count once the pipeline
    // holds real samples and the line has actually been seen high.
    always_comb begin
        flush_d   = {flush_q[0], 1'b1};
        line_ok_d = line_ok_q | (flush_q[1] & rxd_sync_q);
    end

    assign fall_edge = line_ok_q & rxd_prev_q & ~rxd_sync_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        data_byte_d  = data_byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        rx_busy_d    = rx_busy_q;

        if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                idx_d = '0;
                if (fall_edge) begin
                    state_d   = S_START;
                    rx_busy_d = 1'b1;
                end
            end
            S_START: begin
                if (sample_now && bit_val) begin
                    // Start bit did not hold low: treat as a glitch.
                    state_d   = S_IDLE;
                    rx_busy_d = 1'b0;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (sample_now) begin
                    shift_d = {bit_val, shift_q[7:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (sample_now) begin
                    rx_busy_d = 1'b0;
                    cnt_d     = '0;
                    if (bit_val) begin
                        data_byte_d  = shift_q;
                        byte_valid_d = 1'b1;
                        state_d      = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rxd_sync_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                rx_busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta_q   <= 1'b1;
            rxd_sync_q   <= 1'b1;
            rxd_prev_q   <= 1'b1;
            flush_q      <= 2'b00;
            line_ok_q    <= 1'b0;
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            idx_q        <= '0;
            shift_q      <= 8'h00;
            data_byte_q  <= 8'h00;
            byte_valid_q <= 1'b0;
            rx_busy_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rxd_meta_q   <= rxd;
            rxd_sync_q   <= rxd_meta_q;
            rxd_prev_q   <= rxd_sync_q;
            flush_q      <= flush_d;
            line_ok_q    <= line_ok_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            data_byte_q  <= data_byte_d;
            byte_valid_q <= byte_valid_d;
            rx_busy_q    <= rx_busy_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_byte  = data_byte_q;
    assign byte_valid = byte_valid_q;
    assign rx_busy    = rx_busy_q;
    assign frame_err  = frame_err_q;

endmodule
